// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 strip driver.
// Optional gamma correction is selected with WS2812_GAMMA_EN.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_LATCH
    } ws_state_t;

    localparam int unsigned DEF_T0H_CYC    = 40;
    localparam int unsigned DEF_T1H_CYC    = 80;
    localparam int unsigned DEF_TBIT_CYC   = 125;
    localparam int unsigned DEF_TLATCH_CYC = 8000;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    function automatic logic [23:0] pack_grb(input logic [7:0] g,
                                             input logic [7:0] r,
                                             input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// NRZ bit timer: one start strobe produces one high/low bit period.
// bit_done marks the final cycle so the next bit can start with no gap.
module ws2812_bit_encoder #(
    parameter int unsigned T0H_CYC  = 40,
    parameter int unsigned T1H_CYC  = 80,
    parameter int unsigned TBIT_CYC = 125
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_bit,
    output logic o_wave,
    output logic o_bit_done
);

    localparam int unsigned PW = $clog2(TBIT_CYC) + 1;
    localparam logic [PW-1:0] PH_LAST = PW'(TBIT_CYC - 1);
    localparam logic [PW-1:0] PH_T0H  = PW'(T0H_CYC);
    localparam logic [PW-1:0] PH_T1H  = PW'(T1H_CYC);

    logic [PW-1:0] r_phase;
    logic          r_active;
    logic [PW-1:0] w_thr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase  <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_phase  <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_phase == PH_LAST) begin
                r_active <= 1'b0;
            end else begin
                r_phase <= r_phase + PW'(1);
            end
        end
    end

    assign w_thr      = i_bit ? PH_T1H : PH_T0H;
    assign o_wave     = r_active && (r_phase < w_thr);
    assign o_bit_done = r_active && (r_phase == PH_LAST);

endmodule

// File: rtl/ws2812_gamma_rom.sv
// Registered gamma-2.2 lookup for three colour channels (one cycle latency).
// Compiled only when WS2812_GAMMA_EN is defined.
`ifdef WS2812_GAMMA_EN
module ws2812_gamma_rom
    import ws2812_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_vld,
    input  logic [7:0] i_g,
    input  logic [7:0] i_r,
    input  logic [7:0] i_b,
    output logic       o_vld,
    output grb_t       o_grb
);

    function automatic logic [2047:0] build_lut();
        logic [2047:0] lut;
        real           v;
        for (int unsigned i = 0; i < 256; i++) begin
            v = (real'(i) / 255.0) ** 2.2;
            lut[i*8 +: 8] = 8'($rtoi(v * 255.0 + 0.5));
        end
        return lut;
    endfunction

    localparam logic [2047:0] GAMMA_LUT = build_lut();

    logic r_vld;
    grb_t r_grb;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= 1'b0;
            r_grb <= '0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_grb.g <= GAMMA_LUT[{i_g, 3'b000} +: 8];
                r_grb.r <= GAMMA_LUT[{i_r, 3'b000} +: 8];
                r_grb.b <= GAMMA_LUT[{i_b, 3'b000} +: 8];
            end
        end
    end

    assign o_vld = r_vld;
    assign o_grb = r_grb;

endmodule
`endif

// File: rtl/ws2812_strip_driver.sv
// Single-strip WS2812 driver: fetches GRB words one at a time and serialises them.
// Define WS2812_GAMMA_EN to gamma-correct colours at capture (adds one cycle).
module ws2812_strip_driver
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS    = 64,
    parameter int unsigned T0H_CYC     = DEF_T0H_CYC,
    parameter int unsigned T1H_CYC     = DEF_T1H_CYC,
    parameter int unsigned TBIT_CYC    = DEF_TBIT_CYC,
    parameter int unsigned TLATCH_CYC  = DEF_TLATCH_CYC,
    parameter int unsigned TIMEOUT_CYC = 2000
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       start,
    output logic       next_led_request,
    input  logic [7:0] green_in,
    input  logic [7:0] red_in,
    input  logic [7:0] blue_in,
    input  logic       color_valid,
    output logic       strip_out,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int unsigned LW = $clog2(NUM_LEDS) + 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYC) + 1;
    localparam int unsigned TW = $clog2(TLATCH_CYC) + 1;
    localparam logic [LW-1:0] LEDS_N    = LW'(NUM_LEDS);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] LAT_LAST  = TW'(TLATCH_CYC - 1);

    ws_state_t     r_state, w_state_nxt;
    logic [LW-1:0] r_fetch_cnt, r_send_cnt;
    logic [WW-1:0] r_wait;
    logic [TW-1:0] r_lat;
    grb_t          r_hold;
    logic          r_hold_full, r_outstanding;
    logic [23:0]   r_shift;
    logic [4:0]    r_bit_idx;
    logic          r_busy, r_frame_done, r_underrun;

    logic w_accept, w_load_word, w_enc_start, w_next_bit, w_word_done;
    logic w_timeout, w_latch_done, w_req, w_cap, w_hold_wr, w_pipe_busy;
    logic w_wave, w_bit_done;
    grb_t w_hold_data;

    assign w_cap = color_valid && r_outstanding &&
                   (r_state == ST_LOAD || r_state == ST_SEND);

`ifdef WS2812_GAMMA_EN
    logic w_rom_vld;
    grb_t w_rom_grb;

    ws2812_gamma_rom u_gamma (
        .i_clk   (clk_100mhz),
        .i_rst_n (rst_n),
        .i_vld   (w_cap),
        .i_g     (green_in),
        .i_r     (red_in),
        .i_b     (blue_in),
        .o_vld   (w_rom_vld),
        .o_grb   (w_rom_grb)
    );

    // a colour in the ROM stage still counts as occupying the holding slot
    assign w_hold_wr   = w_rom_vld;
    assign w_hold_data = w_rom_grb;
    assign w_pipe_busy = w_rom_vld;
`else
    assign w_hold_wr   = w_cap;
    assign w_hold_data = pack_grb(green_in, red_in, blue_in);
    assign w_pipe_busy = 1'b0;
`endif

    assign w_req = !r_hold_full && !r_outstanding && !w_pipe_busy &&
                   (r_fetch_cnt != '0) &&
                   (r_state == ST_LOAD || r_state == ST_SEND);

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_load_word  = 1'b0;
        w_enc_start  = 1'b0;
        w_next_bit   = 1'b0;
        w_word_done  = 1'b0;
        w_timeout    = 1'b0;
        w_latch_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (r_hold_full) begin
                    w_load_word = 1'b1;
                    w_enc_start = 1'b1;
                    w_state_nxt = ST_SEND;
                end else if (r_wait >= WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_SEND: begin
                if (w_bit_done) begin
                    if (r_bit_idx != 5'd0) begin
                        w_next_bit  = 1'b1;
                        w_enc_start = 1'b1;
                    end else begin
                        w_word_done = 1'b1;
                        if (r_send_cnt == LW'(1)) begin
                            w_state_nxt = ST_LATCH;
                        end else if (r_hold_full) begin
                            w_load_word = 1'b1;
                            w_enc_start = 1'b1;
                        end else begin
                            w_state_nxt = ST_LOAD;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (r_lat >= LAT_LAST) begin
                    w_latch_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt   <= '0;
            r_send_cnt    <= '0;
            r_wait        <= '0;
            r_lat         <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_outstanding <= 1'b0;
            r_shift       <= '0;
            r_bit_idx     <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_done <= w_latch_done;
            if (w_accept) begin
                r_busy        <= 1'b1;
                r_underrun    <= 1'b0;
                r_fetch_cnt   <= LEDS_N;
                r_send_cnt    <= LEDS_N;
                r_hold_full   <= 1'b0;
                r_outstanding <= 1'b0;
            end
            if (w_req) begin
                r_outstanding <= 1'b1;
                r_fetch_cnt   <= r_fetch_cnt - LW'(1);
            end
            if (w_cap) begin
                r_outstanding <= 1'b0;
            end
            if (w_hold_wr) begin
                r_hold      <= w_hold_data;
                r_hold_full <= 1'b1;
            end
            if (w_load_word) begin
                r_shift     <= r_hold;
                r_hold_full <= 1'b0;
                r_bit_idx   <= 5'd23;
            end
            if (w_next_bit) begin
                r_bit_idx <= r_bit_idx - 5'd1;
            end
            if (w_word_done && r_send_cnt != '0) begin
                r_send_cnt <= r_send_cnt - LW'(1);
            end
            if (w_timeout) begin
                r_underrun    <= 1'b1;
                r_outstanding <= 1'b0;
            end
            if (w_latch_done) begin
                r_busy <= 1'b0;
            end
            if (r_state != ST_LOAD || r_hold_full) begin
                r_wait <= '0;
            end else if (r_wait != WAIT_LAST) begin
                r_wait <= r_wait + WW'(1);
            end
            if (r_state != ST_LATCH) begin
                r_lat <= '0;
            end else if (r_lat != LAT_LAST) begin
                r_lat <= r_lat + TW'(1);
            end
        end
    end

    ws2812_bit_encoder #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_enc (
        .i_clk      (clk_100mhz),
        .i_rst_n    (rst_n),
        .i_start    (w_enc_start),
        .i_bit      (r_shift[r_bit_idx]),
        .o_wave     (w_wave),
        .o_bit_done (w_bit_done)
    );

    assign strip_out        = w_wave && (r_state == ST_SEND);
    assign next_led_request = w_req;
    assign busy             = r_busy;
    assign frame_done       = r_frame_done;
    assign underrun         = r_underrun;

endmodule
